// File: rtl/nvram_backup_pkg.sv
// Shared types and constants for the NVRAM backup controller.
// Used by nvram_backup_ctrl and nvram_autosave_timer.
package nvram_backup_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    XFER      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_SHIFT = $clog2(SECTOR_BYTES);

  // Index of the last sector to load: min(sectors, size / 512) - 1.
  // The caller only uses this for images of at least one sector.
  function automatic logic [7:0] load_last_lba(input logic [31:0] size, input int sectors);
    logic [31-SECTOR_SHIFT:0] n;
    n = size[31:SECTOR_SHIFT];
    if (int'(n) >= sectors) return 8'(sectors - 1);
    else return 8'(n - 1'b1);
  endfunction

endpackage

// File: rtl/nvram_autosave_timer.sv
// Idle down-counter for autosave: reloads on every save-RAM write and
// reports expiry once it has counted down to zero.
module nvram_autosave_timer
  import nvram_backup_pkg::*;
#(
  parameter logic [23:0] DLY = 24'd10_000_000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic reload,
  output logic expired
);

  logic [23:0] count_reg;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) count_reg <= '0;
    else if (reload) count_reg <= DLY;
    else if (count_reg != 24'd0) count_reg <= count_reg - 24'd1;
  end

  assign expired = (count_reg == 24'd0);

endmodule

// File: rtl/nvram_backup_ctrl.sv
// Save-RAM backup controller: loads an image from SD on mount and writes it
// back on request. Define NVRAM_AUTOSAVE_EN to add idle-timeout autosave.
module nvram_backup_ctrl
  import nvram_backup_pkg::*;
#(
  parameter int          SECTORS      = 16,
  parameter logic [23:0] AUTOSAVE_DLY = 24'd10_000_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [31:0] img_size,
  input  logic        download,
  input  logic        save_req,
  input  logic        nvram_we,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        bk_ena,
  output logic        bk_busy,
  output logic        bk_reset,
  output logic        dirty
);

  state_t     state_reg, state_next;
  logic [7:0] lba_reg, lba_next;
  logic [7:0] last_reg, last_next;
  logic       rd_reg, rd_next, wr_reg, wr_next;
  logic       ena_reg, ena_next, busy_reg, busy_next;
  logic       bkrst_reg, bkrst_next, dirty_reg, dirty_next;
  logic       load_reg, load_next, abort_reg, abort_next;
  logic       we_seen_reg, we_seen_next;
  logic       mounted_reg, save_reg, download_reg, ack_reg;

  logic mount_ok, save_rise, dl_rise, ack_rise, ack_fall, auto_fire;

  assign mount_ok  = img_mounted & ~mounted_reg & (img_size >= 32'(SECTOR_BYTES));
  assign save_rise = save_req & ~save_reg;
  assign dl_rise   = download & ~download_reg;
  assign ack_rise  = sd_ack & ~ack_reg;
  assign ack_fall  = ~sd_ack & ack_reg;

`ifdef NVRAM_AUTOSAVE_EN
  logic timer_expired;

  nvram_autosave_timer #(.DLY(AUTOSAVE_DLY)) u_timer (
    .clk_sys (clk_sys),
    .reset   (reset),
    .reload  (nvram_we),
    .expired (timer_expired)
  );

  assign auto_fire = timer_expired & dirty_reg;
`else
  logic unused_dly;
  assign unused_dly = ^AUTOSAVE_DLY;
  assign auto_fire  = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      lba_reg      <= '0;
      last_reg     <= '0;
      rd_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      ena_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      bkrst_reg    <= 1'b0;
      dirty_reg    <= 1'b0;
      load_reg     <= 1'b0;
      abort_reg    <= 1'b0;
      we_seen_reg  <= 1'b0;
      mounted_reg  <= 1'b0;
      save_reg     <= 1'b0;
      download_reg <= 1'b0;
      ack_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lba_reg      <= lba_next;
      last_reg     <= last_next;
      rd_reg       <= rd_next;
      wr_reg       <= wr_next;
      ena_reg      <= ena_next;
      busy_reg     <= busy_next;
      bkrst_reg    <= bkrst_next;
      dirty_reg    <= dirty_next;
      load_reg     <= load_next;
      abort_reg    <= abort_next;
      we_seen_reg  <= we_seen_next;
      mounted_reg  <= img_mounted;
      save_reg     <= save_req;
      download_reg <= download;
      ack_reg      <= sd_ack;
    end
  end

  always_comb begin
    state_next   = state_reg;
    lba_next     = lba_reg;
    last_next    = last_reg;
    rd_next      = rd_reg;
    wr_next      = wr_reg;
    ena_next     = ena_reg;
    busy_next    = busy_reg;
    bkrst_next   = 1'b0;
    dirty_next   = dirty_reg | (nvram_we & ena_reg);
    load_next    = load_reg;
    abort_next   = abort_reg;
    we_seen_next = we_seen_reg;

    if (mount_ok) ena_next = 1'b1;
    if (dl_rise)  ena_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // A mount outranks a save that arises in the same cycle.
        if (mount_ok && !dl_rise) begin
          load_next    = 1'b1;
          last_next    = load_last_lba(img_size, SECTORS);
          lba_next     = '0;
          rd_next      = 1'b1;
          wr_next      = 1'b0;
          busy_next    = 1'b1;
          abort_next   = 1'b0;
          we_seen_next = 1'b0;
          state_next   = XFER;
        end else if ((save_rise || auto_fire) && ena_reg && !dl_rise) begin
          load_next    = 1'b0;
          last_next    = 8'(SECTORS - 1);
          lba_next     = '0;
          rd_next      = 1'b0;
          wr_next      = 1'b1;
          busy_next    = 1'b1;
          abort_next   = 1'b0;
          we_seen_next = 1'b0;
          state_next   = XFER;
        end
      end
      XFER: begin
        if (nvram_we) we_seen_next = 1'b1;
        if (dl_rise)  abort_next   = 1'b1;
        if (ack_rise) begin
          rd_next = 1'b0;
          wr_next = 1'b0;
        end else if (ack_fall) begin
          if (lba_reg == last_reg || abort_reg || dl_rise) begin
            state_next = WAIT_DONE;
          end else begin
            lba_next = lba_reg + 8'd1;
            rd_next  = load_reg;
            wr_next  = ~load_reg;
          end
        end
      end
      WAIT_DONE: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        // An aborted transfer leaves dirty alone and never pulses bk_reset.
        if (!abort_reg && !dl_rise) begin
          if (load_reg) begin
            bkrst_next = 1'b1;
            dirty_next = 1'b0;
          end else begin
            dirty_next = we_seen_reg | (nvram_we & ena_reg);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sd_lba   = {24'd0, lba_reg};
  assign sd_rd    = rd_reg;
  assign sd_wr    = wr_reg;
  assign bk_ena   = ena_reg;
  assign bk_busy  = busy_reg;
  assign bk_reset = bkrst_reg;
  assign dirty    = dirty_reg;

endmodule

// File: tb/tb_nvram_backup_ctrl.sv
// Directed bench for nvram_backup_ctrl with a simple SD responder; the
// autosave timing step runs only when NVRAM_AUTOSAVE_EN is defined.
module tb_nvram_backup_ctrl;

  localparam int SECTORS = 16;
`ifdef NVRAM_AUTOSAVE_EN
  localparam logic [23:0] DLY = 24'd100;
`else
  localparam logic [23:0] DLY = 24'd10_000_000;
`endif

  logic        clk_sys;
  logic        reset;
  logic        img_mounted;
  logic [31:0] img_size;
  logic        download;
  logic        save_req;
  logic        nvram_we;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        bk_ena;
  logic        bk_busy;
  logic        bk_reset;
  logic        dirty;

  nvram_backup_ctrl #(.SECTORS(SECTORS), .AUTOSAVE_DLY(DLY)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .img_mounted (img_mounted),
    .img_size    (img_size),
    .download    (download),
    .save_req    (save_req),
    .nvram_we    (nvram_we),
    .sd_ack      (sd_ack),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .bk_ena      (bk_ena),
    .bk_busy     (bk_busy),
    .bk_reset    (bk_reset),
    .dirty       (dirty)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_total = 0;
  int wr_total = 0;
  int req_total = 0;
  int rst_total = 0;
  logic [31:0] lba_log [64];
  int b_rd, b_wr, b_req, b_rst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;
  always @(negedge clk_sys) if (bk_reset === 1'b1) rst_total <= rst_total + 1;

  // SD responder: ack one cycle after a request, hold for three cycles.
  initial begin
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if ((sd_rd || sd_wr) && !sd_ack && !reset) begin
        lba_log[req_total % 64] = sd_lba;
        if (sd_rd) rd_total++;
        else wr_total++;
        req_total++;
        @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat (3) @(negedge clk_sys);
        sd_ack = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic snap();
    b_rd  = rd_total;
    b_wr  = wr_total;
    b_req = req_total;
    b_rst = rst_total;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    cycles(2);
    while (bk_busy !== 1'b0 && t < 2000) begin
      cycles(1);
      t++;
    end
    if (t >= 2000) begin
      n_err++;
      $error("FAIL %s: wait for idle expired after %0d cycles", tag, t);
    end
    check(tag, bk_busy, 1'b0);
    cycles(2);
  endtask

  task automatic wait_lba(input int v, input string tag);
    int t;
    t = 0;
    while (!((sd_lba == 32'(v)) && (sd_rd || sd_wr)) && t < 2000) begin
      cycles(1);
      t++;
    end
    if (t >= 2000) begin
      n_err++;
      $error("FAIL %s: wait for lba %0d expired after %0d cycles", tag, v, t);
    end
    check(tag, sd_lba, 32'(v));
  endtask

  task automatic check_seq(input int base, input int count, input string tag);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < count; i++)
      if (lba_log[(base + i) % 64] !== 32'(i)) ok = 1'b0;
    check(tag, ok, 1'b1);
  endtask

  task automatic mount(input logic [31:0] size);
    img_size    = size;
    img_mounted = 1'b1;
    cycles(1);
    img_mounted = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    img_mounted = 1'b0;
    img_size    = '0;
    download    = 1'b0;
    save_req    = 1'b0;
    nvram_we    = 1'b0;
    cycles(3);
    check("rst_lba", sd_lba, 32'd0);
    check("rst_rd", sd_rd, 1'b0);
    check("rst_wr", sd_wr, 1'b0);
    check("rst_ena", bk_ena, 1'b0);
    check("rst_busy", bk_busy, 1'b0);
    check("rst_bkreset", bk_reset, 1'b0);
    check("rst_dirty", dirty, 1'b0);
    reset = 1'b0;
    cycles(2);

    // Load of a 16-sector image.
    snap();
    mount(32'd8192);
    wait_idle("load16_idle");
    check("load16_reads", rd_total - b_rd, 16);
    check("load16_writes", wr_total - b_wr, 0);
    check_seq(b_req, 16, "load16_lba_seq");
    check("load16_bkreset", rst_total - b_rst, 1);
    check("load16_ena", bk_ena, 1'b1);
    check("load16_dirty", dirty, 1'b0);
    $display("load 8192: reads=%0d bk_reset=%0d", rd_total - b_rd, rst_total - b_rst);

    // Image below one sector: ignored.
    snap();
    mount(32'd256);
    cycles(10);
    check("small_noreq", req_total - b_req, 0);
    check("small_ena", bk_ena, 1'b1);
    $display("mount 256: requests=%0d", req_total - b_req);

    // Short image limits the load to 4 sectors.
    snap();
    mount(32'd2048);
    wait_idle("load4_idle");
    check("load4_reads", rd_total - b_rd, 4);
    check_seq(b_req, 4, "load4_lba_seq");
    check("load4_bkreset", rst_total - b_rst, 1);
    $display("load 2048: reads=%0d", rd_total - b_rd);

    // Write marks dirty; save clears it.
    nvram_we = 1'b1;
    cycles(1);
    nvram_we = 1'b0;
    cycles(1);
    check("we_dirty", dirty, 1'b1);
    snap();
    save_req = 1'b1;
    cycles(1);
    save_req = 1'b0;
    wait_idle("save_idle");
    check("save_writes", wr_total - b_wr, 16);
    check("save_reads", rd_total - b_rd, 0);
    check_seq(b_req, 16, "save_lba_seq");
    check("save_dirty", dirty, 1'b0);
    check("save_nobkreset", rst_total - b_rst, 0);
    $display("save: writes=%0d dirty=%0b", wr_total - b_wr, dirty);

    // Write during sector 5 keeps dirty; a request while busy is dropped.
    snap();
    save_req = 1'b1;
    cycles(1);
    save_req = 1'b0;
    wait_lba(5, "save2_lba5");
    nvram_we = 1'b1;
    cycles(1);
    nvram_we = 1'b0;
    save_req = 1'b1;
    cycles(1);
    save_req = 1'b0;
    wait_idle("save2_idle");
    cycles(8);
    check("save2_requests", req_total - b_req, 16);
    check("save2_dirty", dirty, 1'b1);
    $display("save with write at lba 5: requests=%0d dirty=%0b", req_total - b_req, dirty);

    // Mount and save request in one cycle: load wins.
    snap();
    img_size    = 32'd8192;
    img_mounted = 1'b1;
    save_req    = 1'b1;
    cycles(1);
    img_mounted = 1'b0;
    save_req    = 1'b0;
    wait_idle("prio_idle");
    check("prio_reads", rd_total - b_rd, 16);
    check("prio_writes", wr_total - b_wr, 0);
    check("prio_dirty", dirty, 1'b0);
    $display("mount+save same cycle: reads=%0d writes=%0d", rd_total - b_rd, wr_total - b_wr);

    // Download at sector 7 aborts after that sector.
    snap();
    mount(32'd8192);
    wait_lba(7, "dl_lba7");
    download = 1'b1;
    wait_idle("dl_idle");
    check("dl_reads", rd_total - b_rd, 8);
    check_seq(b_req, 8, "dl_lba_seq");
    check("dl_ena", bk_ena, 1'b0);
    check("dl_nobkreset", rst_total - b_rst, 0);
    check("dl_rd_low", sd_rd, 1'b0);
    download = 1'b0;
    $display("download at lba 7: reads=%0d bk_ena=%0b", rd_total - b_rd, bk_ena);

    // Save without a valid image does nothing.
    snap();
    save_req = 1'b1;
    cycles(1);
    save_req = 1'b0;
    cycles(20);
    check("noena_save", req_total - b_req, 0);
    $display("save with bk_ena=0: requests=%0d", req_total - b_req);

    // Reset in the middle of a transfer.
    mount(32'd8192);
    wait_lba(3, "rst_mid_lba3");
    #2;
    reset = 1'b1;
    snap();
    #1;
    check("rstmid_rd", sd_rd, 1'b0);
    check("rstmid_lba", sd_lba, 32'd0);
    check("rstmid_busy", bk_busy, 1'b0);
    check("rstmid_ena", bk_ena, 1'b0);
    cycles(2);
    reset = 1'b0;
    cycles(60);
    check("rstmid_noresume", req_total - b_req, 0);
    check("rstmid_busy_after", bk_busy, 1'b0);
    $display("reset mid-transfer: requests after release=%0d", req_total - b_req);

`ifdef NVRAM_AUTOSAVE_EN
    begin
      int c0;
      int t;
      mount(32'd8192);
      wait_idle("auto_load_idle");
      snap();
      nvram_we = 1'b1;
      c0 = cyc + 1;
      cycles(1);
      nvram_we = 1'b0;
      while (cyc < c0 + 49) cycles(1);
      nvram_we = 1'b1;
      cycles(1);
      nvram_we = 1'b0;
      t = 0;
      while (sd_wr !== 1'b1 && t < 400) begin
        cycles(1);
        t++;
      end
      check("auto_start_window", ((cyc - c0) >= 149) && ((cyc - c0) <= 151), 1'b1);
      $display("autosave: start %0d cycles after first write", cyc - c0);
      wait_idle("auto_idle");
      check("auto_writes", wr_total - b_wr, 16);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nvram_backup_ctrl.md
NVRAM_BACKUP_CTRL -- requirements
Module: nvram_backup_ctrl

Interface
REQ-001 SHALL provide parameter SECTORS, default 16, number of 512-byte sectors per backup image (1..256).
REQ-002 SHALL provide parameter AUTOSAVE_DLY, default 24'd10_000_000, idle clk_sys cycles after last nvram write before autosave.
REQ-003 SHALL provide port clk_sys, input, 1: system clock; all logic on its rising edge.
REQ-004 SHALL provide port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL provide port img_mounted, input, 1: image-mounted strobe, level, edge-detected.
REQ-006 SHALL provide port img_size, input, 32: mounted image size in bytes.
REQ-007 SHALL provide port download, input, 1: ROM download active, level.
REQ-008 SHALL provide port save_req, input, 1: manual save request, level, rising-edge-detected.
REQ-009 SHALL provide port nvram_we, input, 1: core write to save RAM.
REQ-010 SHALL provide port sd_ack, input, 1: SD transfer acknowledge, high while sector in progress.
REQ-011 SHALL provide port sd_lba, output, 32: sector address.
REQ-012 SHALL provide port sd_rd, output, 1: sector read request.
REQ-013 SHALL provide port sd_wr, output, 1: sector write request.
REQ-014 SHALL provide port bk_ena, output, 1: valid backup image mounted.
REQ-015 SHALL provide port bk_busy, output, 1: transfer in progress.
REQ-016 SHALL provide port bk_reset, output, 1: one-cycle pulse after completed load.
REQ-017 SHALL provide port dirty, output, 1: save RAM modified since last load/save.

Function
REQ-018 SHALL implement states IDLE, XFER, WAIT_DONE.
REQ-019 SHALL on img_mounted rising edge with img_size>=512 set bk_ena=1 and start load; img_size<512 leaves bk_ena unchanged, no transfer.
REQ-020 SHALL transfer count N = min(SECTORS, img_size>>9) for load, SECTORS for save.
REQ-021 SHALL on start: sd_lba=0, sd_rd=load, sd_wr=~load, IDLE->XFER, bk_busy=1.
REQ-022 SHALL clear sd_rd and sd_wr on the cycle after sd_ack rising edge.
REQ-023 SHALL on sd_ack falling edge: if sd_lba==N-1 go WAIT_DONE, else increment sd_lba and reassert the same request next cycle.
REQ-024 SHALL in WAIT_DONE, one cycle later, go IDLE, bk_busy=0; after load pulse bk_reset one cycle and clear dirty.
REQ-025 SHALL after save clear dirty unless nvram_we occurred during the save, then keep dirty=1.
REQ-026 SHALL set dirty on any nvram_we while bk_ena=1.
REQ-027 SHALL start save on save_req rising edge only when bk_ena=1 and state IDLE; requests while busy are dropped.
REQ-028 SHALL give load priority over save when both arise in one cycle.
REQ-029 SHALL clear bk_ena on download rising edge; a transfer in progress completes its current sector then returns IDLE with no bk_reset.
REQ-030 SHALL compute sd_lba only in bits [7:0]; bits [31:8] remain 0.

Reset
REQ-031 SHALL on reset asynchronously force IDLE, sd_lba=0, sd_rd=0, sd_wr=0, bk_ena=0, bk_busy=0, bk_reset=0, dirty=0, timer=0, edge registers cleared.
REQ-032 SHALL not resume an aborted transfer after reset release.

Configuration
REQ-033 SHALL with NVRAM_AUTOSAVE_EN defined reload a down-counter to AUTOSAVE_DLY on each nvram_we and start a save when it reaches 0 with dirty=1, bk_ena=1, state IDLE.
REQ-034 SHALL without NVRAM_AUTOSAVE_EN omit the counter; saves occur only via save_req; AUTOSAVE_DLY ignored.

Structure
REQ-035 SHALL place state enum and SECTOR_BYTES=512 in package nvram_backup_pkg.
REQ-036 SHALL implement the autosave counter as sub-module nvram_autosave_timer, instantiated only under NVRAM_AUTOSAVE_EN.

Verification
REQ-037 SHALL test mount img_size=8192, SECTORS=16 -> 16 reads, lba 0..15, one bk_reset pulse, bk_ena=1.
REQ-038 SHALL test mount img_size=2048 -> exactly 4 reads, lba 0..3.
REQ-039 SHALL test save_req edge after one nvram_we -> 16 writes, dirty=0; nvram_we during lba 5 -> dirty=1 at end.
REQ-040 SHALL test download rising at lba 7 -> sector 7 completes, IDLE, bk_ena=0, no bk_reset.
REQ-041 SHALL test NVRAM_AUTOSAVE_EN with AUTOSAVE_DLY=100: nvram_we at t=0 and t=50 -> save starts at t=150±1.
REQ-042 SHALL test reset asserted mid-XFER -> all outputs 0 immediately, no request after release.
